// File: rtl/regfile_pkg.sv
// Shared constants and types for the 16-entry register file (R15 is external, no storage).
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int PC_IDX     = 15;

  typedef logic [DEF_DATA_W-1:0] reg_word_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: selects a stored register, the external R15 value,
// or forwarded write data when the top asserts fwd_en (only under REGFILE_WRITE_BYPASS_EN).
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] regs [PC_IDX],
  input  logic [DATA_W-1:0] r15,
  input  logic              fwd_en,
  input  logic [DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = r15;
    for (int i = 0; i < PC_IDX; i++) begin
      if (addr == ADDR_W'(i)) data = regs[i];
    end
    if (fwd_en) data = fwd_data;
  end

endmodule

// File: rtl/register_file.sv
// Two-read / one-write register file, R0..R14 stored, R15 supplied as PC+8.
// Define REGFILE_WRITE_BYPASS_EN to forward WD3 to a read port reading the address being written.
module register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic [DATA_W-1:0] R15,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2
);

  logic [DATA_W-1:0] regs [PC_IDX];
  logic              fwd1;
  logic              fwd2;

  // A3 == 15 matches no loop index, so writes to R15 fall away naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PC_IDX; i++) regs[i] <= '0;
    end else if (WE3) begin
      for (int i = 0; i < PC_IDX; i++) begin
        if (A3 == ADDR_W'(i)) regs[i] <= WD3;
      end
    end
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  assign fwd1 = WE3 && !rst && (A3 == A1) && (A3 != ADDR_W'(PC_IDX));
  assign fwd2 = WE3 && !rst && (A3 == A2) && (A3 != ADDR_W'(PC_IDX));
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .addr     (A1),
    .regs     (regs),
    .r15      (R15),
    .fwd_en   (fwd1),
    .fwd_data (WD3),
    .data     (RD1)
  );

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .addr     (A2),
    .regs     (regs),
    .r15      (R15),
    .fwd_en   (fwd2),
    .fwd_data (WD3),
    .data     (RD2)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file; honours REGFILE_WRITE_BYPASS_EN if defined.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        WE3;
  logic [3:0]  A1;
  logic [3:0]  A2;
  logic [3:0]  A3;
  logic [31:0] WD3;
  logic [31:0] R15;
  logic [31:0] RD1;
  logic [31:0] RD2;

  int checks;
  int errors;

  logic [31:0] vals [15];

  register_file dut (
    .clk (clk),
    .rst (rst),
    .WE3 (WE3),
    .A1  (A1),
    .A2  (A2),
    .A3  (A3),
    .WD3 (WD3),
    .R15 (R15),
    .RD1 (RD1),
    .RD2 (RD2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; WE3 = 1'b1; A3 = 4'd3; WD3 = 32'hFFFF_0000;
    A1 = 4'd3; A2 = 4'd15; R15 = 32'h0000_0100;
    @(posedge clk); #1;
    checks++;
    if (RD1 !== 32'h0) begin errors++; $display("FAIL reset_rd1 got %h want %h", RD1, 32'h0); end
    checks++;
    if (RD2 !== 32'h0000_0100) begin errors++; $display("FAIL reset_r15 got %h want %h", RD2, 32'h0000_0100); end
    @(negedge clk);
    WE3 = 1'b0; rst = 1'b0; A1 = 4'd3; A2 = 4'd14;
    #1;
    checks++;
    if (RD1 !== 32'h0) begin errors++; $display("FAIL reset_a3 got %h want %h", RD1, 32'h0); end
    checks++;
    if (RD2 !== 32'h0) begin errors++; $display("FAIL reset_a14 got %h want %h", RD2, 32'h0); end
  endtask

  task automatic test_write_all();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      WE3 = 1'b1; A3 = 4'(i); WD3 = vals[i]; A1 = 4'(i); A2 = 4'(i);
      @(posedge clk); #1;
      checks++;
      if (RD1 !== vals[i]) begin errors++; $display("FAIL write_rd1 r%0d got %h want %h", i, RD1, vals[i]); end
      checks++;
      if (RD2 !== vals[i]) begin errors++; $display("FAIL write_rd2 r%0d got %h want %h", i, RD2, vals[i]); end
    end
    @(negedge clk);
    WE3 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      A1 = 4'(i); A2 = 4'(14 - i);
      #1;
      checks++;
      if (RD1 !== vals[i]) begin errors++; $display("FAIL readback_rd1 r%0d got %h want %h", i, RD1, vals[i]); end
      checks++;
      if (RD2 !== vals[14-i]) begin errors++; $display("FAIL readback_rd2 r%0d got %h want %h", 14 - i, RD2, vals[14-i]); end
    end
  endtask

  task automatic test_r15();
    @(negedge clk);
    WE3 = 1'b0; R15 = 32'h0000_0003; A1 = 4'd15; A2 = 4'd15;
    #1;
    checks++;
    if (RD1 !== 32'h3 || RD2 !== 32'h3) begin
      errors++; $display("FAIL r15_read got %h/%h want %h", RD1, RD2, 32'h3);
    end
    WE3 = 1'b1; A3 = 4'd15; WD3 = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    checks++;
    if (RD1 !== 32'h3 || RD2 !== 32'h3) begin
      errors++; $display("FAIL r15_write_discard got %h/%h want %h", RD1, RD2, 32'h3);
    end
    // no stored register may have been hit by the discarded write
    A1 = 4'd14; A2 = 4'd0;
    #1;
    checks++;
    if (RD1 !== vals[14] || RD2 !== vals[0]) begin
      errors++; $display("FAIL r15_write_side got %h/%h want %h/%h", RD1, RD2, vals[14], vals[0]);
    end
    @(negedge clk);
    WE3 = 1'b0;
  endtask

  task automatic test_we_off();
    @(negedge clk);
    WE3 = 1'b0; A3 = 4'd5; WD3 = 32'hDEAD_BEEF; A1 = 4'd5; A2 = 4'd5;
    @(posedge clk); #1;
    checks++;
    if (RD1 !== vals[5]) begin errors++; $display("FAIL we_off got %h want %h", RD1, vals[5]); end
  endtask

  task automatic test_same_addr();
    logic [31:0] exp_pre;
`ifdef REGFILE_WRITE_BYPASS_EN
    exp_pre = 32'hA5A5_A5A5;
`else
    exp_pre = vals[7];
`endif
    @(negedge clk);
    WE3 = 1'b1; A3 = 4'd7; WD3 = 32'hA5A5_A5A5; A1 = 4'd7; A2 = 4'd6;
    #1;
    checks++;
    if (RD1 !== exp_pre) begin errors++; $display("FAIL same_addr_pre got %h want %h", RD1, exp_pre); end
    checks++;
    if (RD2 !== vals[6]) begin errors++; $display("FAIL same_addr_other got %h want %h", RD2, vals[6]); end
    @(posedge clk); #1;
    checks++;
    if (RD1 !== 32'hA5A5_A5A5) begin errors++; $display("FAIL same_addr_post got %h want %h", RD1, 32'hA5A5_A5A5); end
    @(negedge clk);
    WE3 = 1'b0;
    vals[7] = 32'hA5A5_A5A5;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    WE3 = 1'b1; A3 = 4'd2; WD3 = 32'h1234_5678; A1 = 4'd2; A2 = 4'd9;
    @(posedge clk); #1;
    checks++;
    if (RD1 !== 32'h1234_5678) begin errors++; $display("FAIL async_pre got %h want %h", RD1, 32'h1234_5678); end
    WE3 = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (RD1 !== 32'h0) begin errors++; $display("FAIL async_clear got %h want %h", RD1, 32'h0); end
    checks++;
    if (RD2 !== 32'h0) begin errors++; $display("FAIL async_clear_r9 got %h want %h", RD2, 32'h0); end
    A2 = 4'd15; R15 = 32'h0000_0008;
    #1;
    checks++;
    if (RD2 !== 32'h8) begin errors++; $display("FAIL async_r15 got %h want %h", RD2, 32'h8); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_race();
    @(negedge clk);
    WE3 = 1'b1; A3 = 4'd4; WD3 = 32'hCAFE_F00D; A1 = 4'd4; A2 = 4'd4;
    @(posedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (RD1 !== 32'h0) begin errors++; $display("FAIL reset_race got %h want %h", RD1, 32'h0); end
    @(negedge clk);
    rst = 1'b0; WE3 = 1'b0;
    #1;
    checks++;
    if (RD2 !== 32'h0) begin errors++; $display("FAIL reset_race_after got %h want %h", RD2, 32'h0); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vals[0]  = 32'h0F0F_0F0F; vals[1]  = 32'h39FC_FCFF; vals[2]  = 32'h0000_0002;
    vals[3]  = 32'h3333_3333; vals[4]  = 32'h4444_0004; vals[5]  = 32'h5555_AAAA;
    vals[6]  = 32'h6600_0066; vals[7]  = 32'h7777_7777; vals[8]  = 32'h8000_0008;
    vals[9]  = 32'h9999_0000; vals[10] = 32'hAAAA_5555; vals[11] = 32'hB00B_B00B;
    vals[12] = 32'hC0C0_C0C0; vals[13] = 32'hD15E_A5ED; vals[14] = 32'hEEEE_EEE1;
    test_reset();
    test_write_all();
    test_r15();
    test_we_off();
    test_same_addr();
    test_async_reset();
    test_reset_race();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
